// File: rtl/param_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo_if
// Description : Handshake and status bundle for param_sync_fifo.
//               The master side drives write/read requests; the slave side
//               (the FIFO) returns read data, occupancy and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_sync_fifo_if #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
);

  localparam int CW = $clog2(DEPTH + 1);

  // Requests from the producer/consumer side
  logic             i_wren;
  logic [WIDTH-1:0] i_wrdata;
  logic             i_rden;
  logic             i_err_clr;

  // Data and status returned by the FIFO
  logic [WIDTH-1:0] o_rddata;
  logic             o_rdvalid;
  logic             o_full;
  logic             o_alm_full;
  logic             o_empty;
  logic             o_alm_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wren,
    output i_wrdata,
    output i_rden,
    output i_err_clr,
    input  o_rddata,
    input  o_rdvalid,
    input  o_full,
    input  o_alm_full,
    input  o_empty,
    input  o_alm_empty,
    input  o_count,
    input  o_overflow,
    input  o_underflow
  );

  modport slave (
    input  i_wren,
    input  i_wrdata,
    input  i_rden,
    input  i_err_clr,
    output o_rddata,
    output o_rdvalid,
    output o_full,
    output o_alm_full,
    output o_empty,
    output o_alm_empty,
    output o_count,
    output o_overflow,
    output o_underflow
  );

endinterface
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo
// Description : Parametrised single-clock FIFO with exact occupancy count,
//               programmable almost-full / almost-empty thresholds, correct
//               full/empty at any depth (including non-power-of-2), selectable
//               registered or first-word-fall-through read, and sticky
//               overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 4,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  param_sync_fifo_if.slave       bus
);

  // Count must represent 0..DEPTH inclusive, pointers only 0..DEPTH-1.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF     = CW'(DEPTH - AF_THRESH);
  localparam logic [CW-1:0] CNT_AE     = CW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // --------------------------------------------------------------------------
  // Status decode: derived only from the registered count so that flags
  // never combinationally depend on the same-cycle requests.
  // --------------------------------------------------------------------------
  logic empty;
  logic full;
  logic rd_acc;
  logic wr_acc;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);

  // A read is accepted whenever there is data; a write is accepted when there
  // is room, or when a simultaneous accepted read frees the slot at full.
  assign rd_acc = bus.i_rden & ~empty;
  assign wr_acc = bus.i_wren & (~full | rd_acc);

  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_alm_full  = (count >= CNT_AF);
  assign bus.o_alm_empty = (count <= CNT_AE);
  assign bus.o_count     = count;
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;

  // Explicit wrap at DEPTH-1 keeps non-power-of-2 depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Storage array: written on accepted writes only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem[wr_ptr] <= bus.i_wrdata;
    end
  end

  // Write/read pointers advance on their respective accepts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Occupancy tracks accepts; simultaneous read+write leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new rejection in the clear cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (bus.i_wren & ~wr_acc) | (overflow  & ~bus.i_err_clr);
      underflow <= (bus.i_rden & ~rd_acc) | (underflow & ~bus.i_err_clr);
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented directly; a request pops it.
      assign bus.o_rddata  = mem[rd_ptr];
      assign bus.o_rdvalid = ~empty;
    end else begin : g_regrd
      logic [WIDTH-1:0] rd_data;
      logic             rd_valid;

      // Registered read: data appears one cycle after the accept and holds.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_data <= mem[rd_ptr];
          end
        end
      end

      assign bus.o_rddata  = rd_data;
      assign bus.o_rdvalid = rd_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock synchronous FIFO; next-generation replacement for the fixed 10x128 FIFO used on the datapath. It adds:
- exact occupancy count;
- programmable almost-full and almost-empty thresholds;
- correct full/empty at any DEPTH, including non-power-of-2;
- registered or first-word-fall-through (FWFT) read mode;
- sticky overflow/underflow error flags.

Parameters:
WIDTH, 128, data width in bits
DEPTH, 16, number of entries (>=2; non-power-of-2 legal)
AF_THRESH, 4, o_alm_full asserts when free slots <= AF_THRESH (1..DEPTH-1)
AE_THRESH, 2, o_alm_empty asserts when occupancy <= AE_THRESH (1..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
CW, $clog2(DEPTH+1), count width (derived; not overridden)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-low reset
i_wren  in  1  write request
i_wrdata  in  WIDTH  write data
i_rden  in  1  read request / pop
i_err_clr  in  1  clears sticky error flags
o_rddata  out  WIDTH  read data
o_rdvalid  out  1  o_rddata valid qualifier
o_full  out  1  count == DEPTH
o_alm_full  out  1  count >= DEPTH-AF_THRESH
o_empty  out  1  count == 0
o_alm_empty  out  1  count <= AE_THRESH
o_count  out  CW  current occupancy
o_overflow  out  1  sticky: write rejected
o_underflow  out  1  sticky: read rejected

Behaviour:
- Reset (clk edge with reset=0): write ptr, read ptr and count -> 0; o_rddata -> 0; o_rdvalid, o_overflow, o_underflow -> 0. Memory contents are not cleared.
- Reset takes priority over every other input and aborts any in-flight read.
- After reset: o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_count=0.
- All flags and o_count are combinational decodes of registered count only; they never depend on same-cycle i_wren/i_rden.
- Read accept: rd_acc = i_rden & !o_empty.
- Write accept: wr_acc = i_wren & (!o_full | rd_acc). At full, a simultaneous read+write is accepted and count stays DEPTH.
- At empty, a simultaneous read+write accepts the write only; count goes 0->1 and o_underflow sets.
- Pointers advance by 1 on accept and wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- Count next = count + wr_acc - rd_acc.
- FWFT=0:
  - On rd_acc, o_rddata <= mem[rd_ptr] and o_rdvalid <= 1 at the next edge.
  - Otherwise o_rdvalid <= 0 and o_rddata holds its last value.
  - Latency is 1 cycle from accept to data.
- FWFT=1:
  - o_rddata = mem[rd_ptr] and o_rdvalid = !o_empty, both combinational from registered state.
  - i_rden pops the current head.
  - Data written into an empty FIFO is visible the cycle after the write edge.
- o_overflow sets on i_wren & !wr_acc. o_underflow sets on i_rden & !rd_acc.
- Error flags hold until i_err_clr=1 at an edge or reset. If clear and set occur in the same cycle, set wins.
- Rejected operations change no pointer, count or data.

Test Plan:
- DEPTH=10, FWFT=0: reset, write 0x1..0xA on 10 consecutive cycles.
  -> o_count = 10; o_full=1; o_alm_full first at count 6; o_overflow=0.
- Same FIFO full: 11th write 0xB -> rejected, o_overflow=1, count stays 10. Pulse i_err_clr -> o_overflow=0.
- Same FIFO full: 10 reads -> o_rddata = 0x1..0xA, each one cycle after its accept. o_empty=1 after the last read; o_alm_empty first at count 2.
- Empty FIFO: i_rden alone -> o_underflow=1, o_rdvalid=0. Simultaneous read+write of 0x55 -> count=1 and o_underflow stays set.
- Full FIFO: 20 cycles of simultaneous read+write -> count stays 10, no overflow, output order strictly FIFO across pointer wrap.
- FWFT=1, DEPTH=10:
  - write 0xAA -> next cycle o_rdvalid=1, o_rddata=0xAA with no i_rden.
  - pop -> o_empty=1.
  - assert reset mid-stream with count=5 -> count 0, all flags at reset values.
